// File: rtl/wfg_pat_sched_pkg.sv
// wfg_pat_sched_pkg: shared state encoding and default sizing for the pattern scheduler
package wfg_pat_sched_pkg;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AXIS_WIDTH = 32;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/wfg_pat_sched_timer.sv
// wfg_pat_sched_timer: clock/subcycle counters producing the period-start pulse
// Ports: clk, rst_n (sync, active-low); run = scheduler in RUN, en = stays in RUN next cycle;
//   cfg_subcycle/cfg_sync = counter limits; sync = period-start pulse; subcycle_cnt = current subcycle.
module wfg_pat_sched_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       en,
  input  logic [7:0] cfg_subcycle,
  input  logic [7:0] cfg_sync,
  output logic       sync,
  output logic [7:0] subcycle_cnt
);
  logic [7:0] clk_cnt;
  logic       clk_wrap;
  assign clk_wrap = clk_cnt >= cfg_subcycle;
  // counters are zero on entry to RUN, so the first RUN cycle pulses automatically
  assign sync = run && clk_cnt == 8'd0 && subcycle_cnt == 8'd0;
  // clearing on !en as well keeps the counters at 0 in the first IDLE cycle
  always_ff @(posedge clk) begin
    if (!rst_n || !run || !en) begin
      clk_cnt      <= 8'd0;
      subcycle_cnt <= 8'd0;
    end else begin
      clk_cnt      <= clk_wrap ? 8'd0 : clk_cnt + 8'd1;
      subcycle_cnt <= !clk_wrap ? subcycle_cnt : (subcycle_cnt >= cfg_sync ? 8'd0 : subcycle_cnt + 8'd1);
    end
  end
endmodule

// File: rtl/wfg_pat_sched.sv
// wfg_pat_sched: periodic pattern-table scheduler emitting one AXI-Stream word per sync period
// Ports: clk, rst_n (sync, active-low); ctrl_en_q_i enable; cfg_* timing/length config;
//   tbl_* table write port; pat_sync_o / pat_subcycle_cnt_o timing outputs;
//   wfg_axis_* pattern stream; underrun_o / underrun_clr_i sticky overwrite flag.
// Macro WFG_PAT_SCHED_UNDERRUN_EN enables the underrun flag; otherwise underrun_o is 0.
module wfg_pat_sched
  import wfg_pat_sched_pkg::*;
#(
  parameter int AXIS_WIDTH = DEF_AXIS_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_en_q_i,
  input  logic [7:0]            cfg_subcycle_q_i,
  input  logic [7:0]            cfg_sync_q_i,
  input  logic [AW-1:0]         cfg_len_q_i,
  input  logic                  tbl_we_i,
  input  logic [AW-1:0]         tbl_addr_i,
  input  logic [AXIS_WIDTH-1:0] tbl_wdata_i,
  output logic                  pat_sync_o,
  output logic [7:0]            pat_subcycle_cnt_o,
  output logic                  wfg_axis_tvalid_o,
  input  logic                  wfg_axis_tready_i,
  output logic                  wfg_axis_tlast_o,
  output logic [AXIS_WIDTH-1:0] wfg_axis_tdata_o,
  output logic                  underrun_o,
  input  logic                  underrun_clr_i
);
  state_t                state;
  logic                  run;
  logic [AXIS_WIDTH-1:0] tbl [DEPTH];
  logic [AW-1:0]         idx;
  logic                  pend_v;
  logic                  pend_l;
  logic [AXIS_WIDTH-1:0] pend_d;
  logic                  cur_l;
  assign run = state == RUN;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= ctrl_en_q_i ? RUN : IDLE;
  end
  wfg_pat_sched_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .en           (ctrl_en_q_i),
    .cfg_subcycle (cfg_subcycle_q_i),
    .cfg_sync     (cfg_sync_q_i),
    .sync         (pat_sync_o),
    .subcycle_cnt (pat_subcycle_cnt_o)
  );
  // table is not reset; reads see pre-write contents in the write cycle
  always_ff @(posedge clk) begin
    if (tbl_we_i) tbl[tbl_addr_i] <= tbl_wdata_i;
  end
  // the sync cycle presents the table word directly; later cycles replay the held copy
  assign cur_l             = idx == cfg_len_q_i;
  assign wfg_axis_tvalid_o = pat_sync_o || pend_v;
  assign wfg_axis_tdata_o  = pat_sync_o ? tbl[idx] : pend_d;
  assign wfg_axis_tlast_o  = pat_sync_o ? cur_l : pend_l;
  always_ff @(posedge clk) begin
    if (!rst_n || !run || !ctrl_en_q_i) begin
      idx    <= '0;
      pend_v <= 1'b0;
      pend_l <= 1'b0;
      pend_d <= '0;
    end else if (pat_sync_o) begin
      idx    <= cur_l ? '0 : idx + 1'b1;
      pend_v <= !wfg_axis_tready_i;
      pend_l <= cur_l;
      pend_d <= tbl[idx];
    end else if (wfg_axis_tready_i) begin
      pend_v <= 1'b0;
    end
  end
`ifdef WFG_PAT_SCHED_UNDERRUN_EN
  // a sync while a word is still held displaces that word; set wins over clear
  always_ff @(posedge clk) begin
    if (!rst_n)                     underrun_o <= 1'b0;
    else if (pat_sync_o && pend_v)  underrun_o <= 1'b1;
    else if (underrun_clr_i)        underrun_o <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = underrun_clr_i;
  assign underrun_o = 1'b0;
`endif
endmodule
